// File: rtl/axi_router_pkg.sv
// Shared definitions for the AXI write-channel router.
//   - state_e      : transaction FSM encoding (IDLE, ADDR, DATA, RESP)
//   - OKAY/DECERR  : BRESP codes the router issues or forwards
//   - midx_bits()  : width of a master index (at least 1 bit)
//   - ids_bits()   : slave-side ID width (master ID plus master index)
package axi_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  function automatic int midx_bits(input int num_m);
    return (num_m > 1) ? $clog2(num_m) : 1;
  endfunction

  function automatic int ids_bits(input int id_bits, input int num_m);
    return id_bits + midx_bits(num_m);
  endfunction

endpackage

// File: rtl/axi_write_router_if.sv
// Bundle of every AW/W/B signal around the router.
// Master-side buses are indexed [NUM_M], slave-side buses [NUM_S].
//
// Handshake rule for all three channels: a beat transfers on a rising ACLK
// edge where VALID and READY are both high; VALID, once raised, stays high
// with stable payload until that edge and never waits on READY, while READY
// may depend combinationally on VALID.
//
// Modports:
//   slave  : the router itself (serves the upstream masters, drives the
//            AW/W/BREADY side of the downstream slaves)
//   master : the surrounding fabric / environment (the reverse directions)
interface axi_write_router_if #(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 2,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = 4,
  parameter int LEN_BITS  = 4
);
  import axi_router_pkg::*;

  localparam int STRB_BITS = DATA_BITS / 8;
  localparam int IDS_BITS  = ids_bits(ID_BITS, NUM_M);

  // master side
  logic [NUM_M-1:0][ID_BITS-1:0]   AWID_M;
  logic [NUM_M-1:0][ADDR_BITS-1:0] AWADDR_M;
  logic [NUM_M-1:0][LEN_BITS-1:0]  AWLEN_M;
  logic [NUM_M-1:0][2:0]           AWSIZE_M;
  logic [NUM_M-1:0][1:0]           AWBURST_M;
  logic [NUM_M-1:0]                AWVALID_M;
  logic [NUM_M-1:0]                AWREADY_M;
  logic [NUM_M-1:0][DATA_BITS-1:0] WDATA_M;
  logic [NUM_M-1:0][STRB_BITS-1:0] WSTRB_M;
  logic [NUM_M-1:0]                WLAST_M;
  logic [NUM_M-1:0]                WVALID_M;
  logic [NUM_M-1:0]                WREADY_M;
  logic [NUM_M-1:0][ID_BITS-1:0]   BID_M;
  logic [NUM_M-1:0][1:0]           BRESP_M;
  logic [NUM_M-1:0]                BVALID_M;
  logic [NUM_M-1:0]                BREADY_M;

  // slave side
  logic [NUM_S-1:0][IDS_BITS-1:0]  AWID_S;
  logic [NUM_S-1:0][ADDR_BITS-1:0] AWADDR_S;
  logic [NUM_S-1:0][LEN_BITS-1:0]  AWLEN_S;
  logic [NUM_S-1:0][2:0]           AWSIZE_S;
  logic [NUM_S-1:0][1:0]           AWBURST_S;
  logic [NUM_S-1:0]                AWVALID_S;
  logic [NUM_S-1:0]                AWREADY_S;
  logic [NUM_S-1:0][DATA_BITS-1:0] WDATA_S;
  logic [NUM_S-1:0][STRB_BITS-1:0] WSTRB_S;
  logic [NUM_S-1:0]                WLAST_S;
  logic [NUM_S-1:0]                WVALID_S;
  logic [NUM_S-1:0]                WREADY_S;
  logic [NUM_S-1:0][IDS_BITS-1:0]  BID_S;
  logic [NUM_S-1:0][1:0]           BRESP_S;
  logic [NUM_S-1:0]                BVALID_S;
  logic [NUM_S-1:0]                BREADY_S;

  modport slave (
    input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M, BREADY_M,
    input  AWREADY_S, WREADY_S, BID_S, BRESP_S, BVALID_S,
    output AWREADY_M, WREADY_M, BID_M, BRESP_M, BVALID_M,
    output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    output WDATA_S, WSTRB_S, WLAST_S, WVALID_S, BREADY_S
  );

  modport master (
    output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    output WDATA_M, WSTRB_M, WLAST_M, WVALID_M, BREADY_M,
    output AWREADY_S, WREADY_S, BID_S, BRESP_S, BVALID_S,
    input  AWREADY_M, WREADY_M, BID_M, BRESP_M, BVALID_M,
    input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S, BREADY_S
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over NUM_M requesters.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req       : request vector
//   advance   : commit the current grant as the new last_grant
//   gnt       : one-hot grant (combinational, zero when no request)
//   gnt_idx   : binary index of the grant
// Search starts at last_grant+1 (mod NUM_M); after reset last_grant is
// NUM_M-1 so requester 0 wins the first contest.
module rr_arbiter #(
  parameter int NUM_M    = 2,
  parameter int IDX_BITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M-1:0]    req,
  input  logic                advance,
  output logic [NUM_M-1:0]    gnt,
  output logic [IDX_BITS-1:0] gnt_idx
);

  logic [IDX_BITS-1:0] last_grant;
  logic                found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      int cand;
      cand = (int'(last_grant) + k) % NUM_M;
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = IDX_BITS'(cand);
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDX_BITS'(NUM_M - 1);
    end else if (advance && found) begin
      last_grant <= gnt_idx;
    end
  end

endmodule

// File: rtl/axi_write_router.sv
// AXI write-channel router: NUM_M masters to NUM_S address-decoded slaves,
// one transaction at a time.
// Ports:
//   ACLK       : clock, rising edge
//   ARESET     : synchronous active-high reset; aborts any transaction
//   bus        : all AW/W/B channels (axi_write_router_if, slave modport)
//   state_dbg  : current FSM state (IDLE=0, ADDR=1, DATA=2, RESP=3)
// A request seen in IDLE is arbitrated and decoded into registered grant
// state; AW, W and B then pass combinationally between the granted master
// and slave. Unmapped addresses are absorbed by an internal default slave
// that accepts the data and answers DECERR. WLAST toward the slave comes
// from the router's own beat counter; the master's WLAST is not used.
module axi_write_router
  import axi_router_pkg::*;
#(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 2,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = 4,
  parameter int LEN_BITS  = 4,
  parameter logic [0:NUM_S-1][ADDR_BITS-1:0] S_BASE = {32'h0001_0000, 32'h0000_0000},
  parameter logic [0:NUM_S-1][ADDR_BITS-1:0] S_MASK = {32'hFFFF_0000, 32'hFFFF_0000}
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  axi_write_router_if.slave      bus,
  output logic [1:0]             state_dbg
);

  localparam int MIDX_BITS = midx_bits(NUM_M);
  localparam int IDS_BITS  = ID_BITS + MIDX_BITS;
  localparam int SIDX_BITS = (NUM_S > 1) ? $clog2(NUM_S) : 1;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] ADDR = ST_ADDR;
  localparam logic [1:0] DATA = ST_DATA;
  localparam logic [1:0] RESP = ST_RESP;

  logic [1:0]           state;
  logic [MIDX_BITS-1:0] gnt_m;
  logic [SIDX_BITS-1:0] gnt_s;
  logic                 decerr;
  logic [LEN_BITS-1:0]  len_r;
  logic [LEN_BITS-1:0]  beat_cnt;
  logic [ID_BITS-1:0]   id_r;

  logic                 any_req;
  logic                 arb_adv;
  logic [NUM_M-1:0]     arb_gnt;
  logic [MIDX_BITS-1:0] arb_idx;

  logic [ADDR_BITS-1:0] req_addr;
  logic [LEN_BITS-1:0]  req_len;
  logic [ID_BITS-1:0]   req_id;
  logic                 dec_hit;
  logic [SIDX_BITS-1:0] dec_idx;

  logic                 aw_hs;
  logic                 w_hs;
  logic                 b_hs;
  logic                 last_beat;
  logic                 b_route_ok;

  // The master's WLAST is deliberately not used.
  logic unused_wlast_m;
  assign unused_wlast_m = ^bus.WLAST_M;

  assign state_dbg = state;
  assign any_req   = |bus.AWVALID_M;
  assign arb_adv   = (state == IDLE) && any_req;
  assign last_beat = (beat_cnt == len_r);

  rr_arbiter #(
    .NUM_M    (NUM_M),
    .IDX_BITS (MIDX_BITS)
  ) u_arb (
    .clk     (ACLK),
    .rst     (ARESET),
    .req     (bus.AWVALID_M),
    .advance (arb_adv),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Select the winning request and decode its address; the lowest-index
  // matching slave wins, no match routes to the internal DECERR slave.
  always_comb begin
    req_addr = '0;
    req_len  = '0;
    req_id   = '0;
    dec_hit  = 1'b0;
    dec_idx  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (arb_gnt[i]) begin
        req_addr = bus.AWADDR_M[i];
        req_len  = bus.AWLEN_M[i];
        req_id   = bus.AWID_M[i];
      end
    end
    for (int s = NUM_S - 1; s >= 0; s--) begin
      if ((req_addr & S_MASK[s]) == S_BASE[s]) begin
        dec_hit = 1'b1;
        dec_idx = SIDX_BITS'(s);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      gnt_m    <= '0;
      gnt_s    <= '0;
      decerr   <= 1'b0;
      len_r    <= '0;
      beat_cnt <= '0;
      id_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= ADDR;
            gnt_m    <= arb_idx;
            gnt_s    <= dec_idx;
            decerr   <= ~dec_hit;
            len_r    <= req_len;
            id_r     <= req_id;
            beat_cnt <= '0;
          end
        end
        ADDR: begin
          if (aw_hs) state <= DATA;
        end
        DATA: begin
          if (w_hs) begin
            // Exit before incrementing so a 16-beat burst never wraps.
            if (last_beat) begin
              state    <= RESP;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RESP: begin
          if (b_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel steering. Everything defaults to zero so idle and
  // non-granted ports stay quiet.
  always_comb begin
    bus.AWREADY_M = '0;
    bus.WREADY_M  = '0;
    bus.BID_M     = '0;
    bus.BRESP_M   = '0;
    bus.BVALID_M  = '0;
    bus.AWID_S    = '0;
    bus.AWADDR_S  = '0;
    bus.AWLEN_S   = '0;
    bus.AWSIZE_S  = '0;
    bus.AWBURST_S = '0;
    bus.AWVALID_S = '0;
    bus.WDATA_S   = '0;
    bus.WSTRB_S   = '0;
    bus.WLAST_S   = '0;
    bus.WVALID_S  = '0;
    bus.BREADY_S  = '0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    b_hs          = 1'b0;
    b_route_ok    = 1'b0;
    case (state)
      ADDR: begin
        if (decerr) begin
          bus.AWREADY_M[gnt_m] = 1'b1;
          aw_hs = bus.AWVALID_M[gnt_m];
        end else begin
          bus.AWVALID_S[gnt_s] = bus.AWVALID_M[gnt_m];
          bus.AWID_S[gnt_s]    = {gnt_m, bus.AWID_M[gnt_m]};
          bus.AWADDR_S[gnt_s]  = bus.AWADDR_M[gnt_m];
          bus.AWLEN_S[gnt_s]   = bus.AWLEN_M[gnt_m];
          bus.AWSIZE_S[gnt_s]  = bus.AWSIZE_M[gnt_m];
          bus.AWBURST_S[gnt_s] = bus.AWBURST_M[gnt_m];
          bus.AWREADY_M[gnt_m] = bus.AWREADY_S[gnt_s];
          aw_hs = bus.AWVALID_M[gnt_m] & bus.AWREADY_S[gnt_s];
        end
      end
      DATA: begin
        if (decerr) begin
          bus.WREADY_M[gnt_m] = 1'b1;
          w_hs = bus.WVALID_M[gnt_m];
        end else begin
          bus.WVALID_S[gnt_s] = bus.WVALID_M[gnt_m];
          bus.WDATA_S[gnt_s]  = bus.WDATA_M[gnt_m];
          bus.WSTRB_S[gnt_s]  = bus.WSTRB_M[gnt_m];
          bus.WLAST_S[gnt_s]  = last_beat;
          bus.WREADY_M[gnt_m] = bus.WREADY_S[gnt_s];
          w_hs = bus.WVALID_M[gnt_m] & bus.WREADY_S[gnt_s];
        end
      end
      RESP: begin
        if (decerr) begin
          bus.BVALID_M[gnt_m] = 1'b1;
          bus.BRESP_M[gnt_m]  = DECERR;
          bus.BID_M[gnt_m]    = id_r;
          b_hs = bus.BREADY_M[gnt_m];
        end else begin
          // The upper ID bits name the owning master; only a response
          // tagged for the granted master is passed through.
          b_route_ok = (bus.BID_S[gnt_s][IDS_BITS-1:ID_BITS] == gnt_m);
          if (b_route_ok) begin
            bus.BVALID_M[gnt_m] = bus.BVALID_S[gnt_s];
            bus.BRESP_M[gnt_m]  = bus.BRESP_S[gnt_s];
            bus.BID_M[gnt_m]    = bus.BID_S[gnt_s][ID_BITS-1:0];
            bus.BREADY_S[gnt_s] = bus.BREADY_M[gnt_m];
          end
          b_hs = b_route_ok & bus.BVALID_S[gnt_s] & bus.BREADY_M[gnt_m];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_write_router.sv
// Self-checking bench for axi_write_router (2 masters, 2 slaves).
module tb_axi_write_router;

  localparam int NUM_M = 2;
  localparam int NUM_S = 2;
  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_D = 2'd2;
  localparam logic [1:0] ST_R = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  axi_write_router_if #(.NUM_M(NUM_M), .NUM_S(NUM_S)) bus ();

  axi_write_router #(.NUM_M(NUM_M), .NUM_S(NUM_S)) dut (
    .ACLK      (clk),
    .ARESET    (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  logic any_out;
  assign any_out = |{bus.AWREADY_M, bus.WREADY_M, bus.BID_M, bus.BRESP_M, bus.BVALID_M,
                     bus.AWID_S, bus.AWADDR_S, bus.AWLEN_S, bus.AWSIZE_S, bus.AWBURST_S,
                     bus.AWVALID_S, bus.WDATA_S, bus.WSTRB_S, bus.WLAST_S, bus.WVALID_S,
                     bus.BREADY_S};

  // ---------------- scoreboard / model state ----------------
  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q[$];       // {wdata, wstrb, wlast} expected at the slave
  int          rr_last;
  bit          req_v   [NUM_M];
  logic [31:0] req_addr[NUM_M];
  int          req_len [NUM_M];
  logic [3:0]  req_id  [NUM_M];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Address map rule: first matching slave in index order, else none.
  function automatic int decode(input logic [31:0] a);
    if ((a & 32'hFFFF_0000) == 32'h0001_0000) return 0;
    if ((a & 32'hFFFF_0000) == 32'h0000_0000) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr(input int sel);
    logic [31:0] r;
    r = $urandom;
    case (sel)
      0:       return {16'h0001, r[15:0]};
      1:       return {16'h0000, r[15:0]};
      default: return {4'h2, r[27:0]};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.AWID_M = '0; bus.AWADDR_M = '0; bus.AWLEN_M = '0; bus.AWSIZE_M = '0;
    bus.AWBURST_M = '0; bus.AWVALID_M = '0;
    bus.WDATA_M = '0; bus.WSTRB_M = '0; bus.WLAST_M = '0; bus.WVALID_M = '0;
    bus.BREADY_M = '0;
    bus.AWREADY_S = '1; bus.WREADY_S = '1;
    bus.BID_S = '0; bus.BRESP_S = '0; bus.BVALID_S = '0;
    for (int i = 0; i < NUM_M; i++) req_v[i] = 1'b0;
  endtask

  task automatic post_req(input int m, input logic [31:0] a, input int len, input logic [3:0] id);
    req_v[m] = 1'b1; req_addr[m] = a; req_len[m] = len; req_id[m] = id;
    bus.AWID_M[m] = id; bus.AWADDR_M[m] = a; bus.AWLEN_M[m] = 4'(len);
    bus.AWSIZE_M[m] = 3'd2; bus.AWBURST_M[m] = 2'b01; bus.AWVALID_M[m] = 1'b1;
  endtask

  // Runs one full transaction for whichever master the round-robin model
  // says should win. wmode: 0 = correct WLAST, 1 = never, 2 = always high.
  task automatic run_txn(input int wmode, input bit stall_w, input bit stall_b,
                         input logic [1:0] slv_resp, output int g, output int wait_cyc);
    int em, es, len, b, cyc, stall_left;
    bit derr, driven, stalled, done, touched;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [36:0] expv;
    em = -1;
    for (int k = 1; k <= NUM_M; k++) begin
      int c;
      c = (rr_last + k) % NUM_M;
      if (em < 0 && req_v[c]) em = c;
    end
    if (em < 0) begin
      $display("FAIL run_txn: no pending request");
      $fatal(1, "bench sequencing error");
    end
    rr_last = em;
    g = em;
    es = decode(req_addr[em]);
    derr = (es < 0);
    len = req_len[em];
    touched = 1'b0;

    // AW phase
    wait_cyc = 0;
    do begin @(negedge clk); #1; wait_cyc++; end while (bus.AWREADY_M == '0 && wait_cyc < 20);
    chk("aw_grant", 64'(bus.AWREADY_M), 64'(1 << em));
    chk("aw_valid_s", 64'(bus.AWVALID_S), derr ? 64'd0 : 64'(1 << es));
    if (!derr) begin
      chk("aw_id_s", 64'(bus.AWID_S[es]), 64'({1'(em), req_id[em]}));
      chk("aw_addr_s", 64'(bus.AWADDR_S[es]), 64'(req_addr[em]));
      chk("aw_len_s", 64'(bus.AWLEN_S[es]), 64'(len));
      chk("aw_sizeburst_s", 64'({bus.AWSIZE_S[es], bus.AWBURST_S[es]}), 64'({3'd2, 2'b01}));
    end
    @(negedge clk);
    bus.AWVALID_M[em] = 1'b0;
    req_v[em] = 1'b0;

    // W phase
    b = 0; cyc = 0; driven = 1'b0; stall_left = stall_w ? 5 : 0;
    while (b <= len && cyc < 120) begin
      if (!driven) begin
        wd = $urandom; ws = 4'($urandom);
        bus.WDATA_M[em] = wd; bus.WSTRB_M[em] = ws; bus.WVALID_M[em] = 1'b1;
        bus.WLAST_M[em] = (wmode == 0) ? (b == len) : (wmode == 2);
        exp_q.push_back({wd, ws, 1'(b == len)});
        driven = 1'b1;
      end
      stalled = stall_w && !derr && (b == 2) && (stall_left > 0);
      if (!derr) bus.WREADY_S[es] = !stalled;
      #1;
      if (derr) begin
        touched = touched | (|bus.AWVALID_S) | (|bus.WVALID_S);
        chk("w_ready_decerr", 64'(bus.WREADY_M[em]), 64'd1);
      end else begin
        chk("w_valid_s", 64'(bus.WVALID_S), 64'(1 << es));
      end
      if (stalled) begin
        chk("w_stall_ready", 64'(bus.WREADY_M[em]), 64'd0);
        chk("w_stall_state", 64'(state_dbg), 64'(ST_D));
        stall_left--;
      end else if (bus.WREADY_M[em]) begin
        expv = exp_q.pop_front();
        if (!derr)
          chk("w_beat", 64'({bus.WDATA_S[es], bus.WSTRB_S[es], bus.WLAST_S[es]}), 64'(expv));
        b++;
        driven = 1'b0;
      end else begin
        chk("w_ready", 64'(bus.WREADY_M[em]), 64'd1);
      end
      @(negedge clk);
      cyc++;
    end
    chk("w_all_beats", 64'(b), 64'(len + 1));
    bus.WVALID_M[em] = 1'b0; bus.WLAST_M[em] = 1'b0;
    bus.WREADY_S = '1;

    // B phase
    if (!derr) begin
      bus.BVALID_S[es] = 1'b1; bus.BID_S[es] = {1'(em), req_id[em]}; bus.BRESP_S[es] = slv_resp;
    end
    stall_left = stall_b ? 5 : 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      bus.BREADY_M[em] = (stall_left == 0);
      #1;
      if (derr) touched = touched | (|bus.AWVALID_S) | (|bus.WVALID_S);
      if (bus.BVALID_M[em]) begin
        if (stall_left > 0) begin
          chk("b_stall_state", 64'(state_dbg), 64'(ST_R));
          if (!derr) chk("b_stall_bready_s", 64'(bus.BREADY_S[es]), 64'd0);
          stall_left--;
        end else begin
          chk("b_valid", 64'(bus.BVALID_M), 64'(1 << em));
          chk("b_id", 64'(bus.BID_M[em]), 64'(req_id[em]));
          chk("b_resp", 64'(bus.BRESP_M[em]), derr ? 64'(2'b11) : 64'(slv_resp));
          done = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("b_done", 64'(done), 64'd1);
    bus.BVALID_S = '0; bus.BID_S = '0; bus.BRESP_S = '0; bus.BREADY_M = '0;
    #1;
    chk("back_to_idle", 64'(state_dbg), 64'(ST_I));
    if (derr) chk("decerr_no_slave_valid", 64'(touched), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int g, lat, cyc, m, sel;
    rst = 1'b1;
    clear_inputs();
    rr_last = NUM_M - 1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", 64'(state_dbg), 64'(ST_I));
    chk("reset_outputs", 64'(any_out), 64'd0);
    rst = 1'b0;

    // Both masters from reset: alternation M0, M1, M0, M1.
    post_req(0, rand_addr(0), 2, 4'h3);
    post_req(1, rand_addr(1), 1, 4'h9);
    for (int k = 0; k < 4; k++) begin
      run_txn(0, 1'b0, 1'b0, 2'b00, g, lat);
      chk("rr_order", 64'(g), 64'(k % 2));
      if (k < 2) post_req(g, rand_addr($urandom_range(0, 1)), $urandom_range(0, 4), 4'($urandom));
    end

    // M0 to 0x0001_0004, 4 beats, OKAY; grant visible one cycle later.
    post_req(0, 32'h0001_0004, 3, 4'hA);
    run_txn(0, 1'b0, 1'b0, 2'b00, g, lat);
    chk("aw_latency", 64'(lat), 64'd1);

    // Unmapped address: internal DECERR slave, 2 beats.
    post_req(0, 32'h2000_0000, 1, 4'h5);
    run_txn(0, 1'b0, 1'b0, 2'b00, g, lat);

    // Single beat with master WLAST never raised, then always raised.
    post_req(1, 32'h0000_0040, 0, 4'h7);
    run_txn(1, 1'b0, 1'b0, 2'b00, g, lat);
    post_req(1, 32'h0001_0080, 3, 4'h2);
    run_txn(2, 1'b0, 1'b0, 2'b10, g, lat);

    // Maximum burst length.
    post_req(0, 32'h0000_1000, 15, 4'hF);
    run_txn(0, 1'b0, 1'b0, 2'b00, g, lat);

    // WREADY_S and BREADY_M stalled 5 cycles.
    post_req(0, 32'h0001_0100, 5, 4'h1);
    run_txn(0, 1'b1, 1'b1, 2'b00, g, lat);

    // Randomized transactions.
    for (int k = 0; k < 8; k++) begin
      m = $urandom_range(0, NUM_M - 1);
      sel = $urandom_range(0, 2);
      post_req(m, rand_addr(sel), $urandom_range(0, 15), 4'($urandom));
      run_txn($urandom_range(0, 2), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10, g, lat);
    end

    // Reset in the middle of DATA, then a fresh write.
    post_req(1, 32'h0000_0200, 7, 4'h6);
    cyc = 0;
    do begin @(negedge clk); #1; cyc++; end while (!bus.AWREADY_M[1] && cyc < 20);
    chk("rst_aw_grant", 64'(bus.AWREADY_M[1]), 64'd1);
    @(negedge clk);
    bus.AWVALID_M[1] = 1'b0; req_v[1] = 1'b0;
    bus.WVALID_M[1] = 1'b1; bus.WDATA_M[1] = $urandom; bus.WSTRB_M[1] = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midburst_rst_state", 64'(state_dbg), 64'(ST_I));
    chk("midburst_rst_outputs", 64'(any_out), 64'd0);
    clear_inputs();
    exp_q.delete();
    rr_last = NUM_M - 1;
    @(negedge clk);
    rst = 1'b0;
    post_req(1, 32'h0001_0300, 2, 4'hC);
    run_txn(0, 1'b0, 1'b0, 2'b00, g, lat);
    chk("post_rst_latency", 64'(lat), 64'd1);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_write_router.md
# axi_write_router

Parametrised AXI write-channel crossbar in the AXI bridge. It routes AW/W/B traffic from NUM_M masters to NUM_S address-decoded slaves, one transaction at a time:
- Round-robin arbitration between masters.
- Master-index ID extension toward the slaves.
- Router-generated WLAST from its own beat counter.
- An internal default slave that returns DECERR for unmapped addresses.

## Interface
Parameters:
- NUM_M, 2, master count (≥1)
- NUM_S, 2, slave count (≥1)
- ADDR_BITS, 32, address width
- DATA_BITS, 32, data width; STRB_BITS = DATA_BITS/8
- ID_BITS, 4, master-side ID width; MIDX_BITS = max(1,$clog2(NUM_M)); IDS_BITS = ID_BITS+MIDX_BITS
- LEN_BITS, 4, burst length width
- S_BASE, {32'h0001_0000, 32'h0000_0000}, [NUM_S][ADDR_BITS] base per slave
- S_MASK, {32'hFFFF_0000, 32'hFFFF_0000}, [NUM_S][ADDR_BITS] decode mask per slave

Ports (master-side buses are [NUM_M] arrays, slave-side buses are [NUM_S] arrays):
- ACLK  in  1  clock; everything is on the rising edge
- ARESET  in  1  synchronous, active-high reset
- AWID_M/AWADDR_M/AWLEN_M/AWSIZE_M/AWBURST_M/AWVALID_M  in  [NUM_M]×(ID/ADDR/LEN/3/2/1)  master write address
- AWREADY_M  out  [NUM_M]  address accept
- WDATA_M/WSTRB_M/WLAST_M/WVALID_M  in  [NUM_M]×(DATA/STRB/1/1)  write data
- WREADY_M  out  [NUM_M]  data accept
- BID_M/BRESP_M/BVALID_M  out  [NUM_M]×(ID/2/1)  write response
- BREADY_M  in  [NUM_M]  response accept
- AWID_S/AWADDR_S/AWLEN_S/AWSIZE_S/AWBURST_S/AWVALID_S  out  [NUM_S]×(IDS/ADDR/LEN/3/2/1)  slave address
- AWREADY_S  in  [NUM_S]
- WDATA_S/WSTRB_S/WLAST_S/WVALID_S  out  [NUM_S]×(DATA/STRB/1/1)  slave data
- WREADY_S  in  [NUM_S]
- BID_S/BRESP_S/BVALID_S  in  [NUM_S]×(IDS/2/1)  slave response
- BREADY_S  out  [NUM_S]

## Operation
- FSM states and transitions:
  - IDLE → ADDR when any AWVALID_M is high.
  - ADDR → DATA on the AW handshake.
  - DATA → RESP on the last W handshake.
  - RESP → IDLE on the B handshake.
- Arbitration (IDLE):
  - Round-robin, starting search at last_grant+1 mod NUM_M.
  - Registers gnt_m, gnt_s, the decerr flag, and len_r = AWLEN_M[gnt_m].
  - last_grant is updated at IDLE→ADDR.
- Decode:
  - Slave s hits when (AWADDR & S_MASK[s]) == S_BASE[s]; the lowest-index hit wins.
  - No hit sets decerr = 1.
- ADDR:
  - AWVALID_S[gnt_s] = AWVALID_M[gnt_m]; AWREADY_M[gnt_m] = AWREADY_S[gnt_s].
  - AWID_S = {gnt_m, AWID}; the other AW fields pass through.
  - If decerr: AWREADY_M[gnt_m] = 1 and no slave sees AWVALID.
- DATA:
  - W is forwarded between the granted pair.
  - beat_cnt increments on each W handshake.
  - WLAST_S = (beat_cnt == len_r); the master's WLAST is ignored.
  - Exit on the handshake with beat_cnt == len_r.
  - If decerr: WREADY_M[gnt_m] = 1 for len_r+1 beats.
- RESP:
  - B is forwarded with BID_M = BID_S[ID_BITS-1:0].
  - BVALID is routed only to master BID_S[IDS_BITS-1:ID_BITS], which must equal gnt_m.
  - If decerr: BVALID_M = 1, BRESP = 2'b11, BID = the latched AWID.
- Non-granted ports and all ports in IDLE: every output is 0.

## Timing
- ARESET: state = IDLE, beat_cnt = 0, last_grant = NUM_M-1, all outputs 0. ARESET mid-burst aborts with no response issued.
- Latency:
  - AWVALID_M to AWVALID_S: 1 cycle, through the registered grant.
  - Handshakes are combinational pass-through after that.
- The AW/W/B VALID/READY rules are per AXI: VALID is never gated by READY.
- Simultaneous requests: exactly one grant per transaction; losers keep VALID held.
- AWLEN = 0: single beat with WLAST_S high on beat 0.
- AWLEN max (15): 16 beats; beat_cnt must not wrap before exit.
- The minimum back-to-back transaction gap is 1 IDLE cycle.

## Structure
- Package axi_router_pkg: state enum {IDLE, ADDR, DATA, RESP}, BRESP constants (OKAY = 2'b00, DECERR = 2'b11), IDS width function.
- Sub-module rr_arbiter (NUM_M requests → one-hot grant + index, advance input).

## Test plan
- M0 writes AWADDR = 0x0001_0004, AWLEN = 3 → S0 sees AWID = {0,id} and 4 beats, WLAST_S0 on beat 3; M0 gets BRESP = 00.
- M0 and M1 both request from reset → M0 is granted first, M1 next, M0 after that (round-robin alternation over 4 transactions).
- AWADDR = 0x2000_0000 with AWLEN = 1 → no slave VALID toggles; 2 beats are accepted; BRESP = 11, BID = the issued AWID.
- AWLEN = 0 with the master asserting WLAST late or never → the transaction completes after 1 beat with WLAST_S = 1.
- WREADY_S and BREADY_M stalled for 5 cycles mid-burst → no beat is lost or duplicated; state holds.
- ARESET asserted during DATA → next cycle all outputs are 0 and state = IDLE; a fresh write then completes normally.
